// File: rtl/sram_word_ctrl_pkg.sv
// Shared constants for the word-level SRAM access sequencer: FSM state
// encodings, cell_r_w strobe polarity and default widths.
package sram_word_ctrl_pkg;

  localparam int ADDR_W_DEF     = 2;
  localparam int ROWS_DEF       = 4;
  localparam int DATA_W_DEF     = 4;
  localparam int ACCESS_CYC_DEF = 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic R_W_WRITE = 1'b1;
  localparam logic R_W_READ  = 1'b0;

endpackage

// File: rtl/sram_word_ctrl_row_decoder.sv
// Row address decoder: one-hot row select when enabled, plus a flag for
// addresses beyond the implemented rows (those never select anything).
module sram_word_ctrl_row_decoder #(
  parameter int ADDR_W = 2,
  parameter int ROWS   = 4
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [ROWS-1:0]   sel,
  output logic              oob
);

  // Decode the address; an out-of-range address yields an all-zero select.
  always_comb begin
    oob = (32'(addr) >= ROWS);
    for (int i = 0; i < ROWS; i++) begin
      sel[i] = en && (32'(addr) == i);
    end
  end

endmodule

// File: rtl/sram_word_ctrl.sv
// Word-level access sequencer for the bitcell array. Accepts read/write
// requests, walks SETUP -> ACCESS -> HOLD around each access so the select
// lines and the r_w strobe never move together, and returns read data over
// a valid/ready response channel.
module sram_word_ctrl
  import sram_word_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int ROWS       = ROWS_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ACCESS_CYC = ACCESS_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ROWS-1:0]   cell_sel,
  output logic              cell_r_w,
  output logic [DATA_W-1:0] cell_in,
  input  logic [DATA_W-1:0] cell_out
);

  localparam int CNT_W = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYC - 1);

  logic [2:0]        state_r;
  logic [2:0]        state_nxt;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [ROWS-1:0]   cell_sel_r;
  logic              cell_r_w_r;
  logic [DATA_W-1:0] cell_in_r;
  logic [DATA_W-1:0] rdata_r;
  logic              err_r;
  logic [ROWS-1:0]   dec_sel;
  logic              dec_oob;
  logic              last_access;

  assign last_access = (cnt_r == LAST_CNT);

  // Select lines are precomputed from the next state so cell_sel is a plain
  // register that is high exactly while the FSM sits in ACCESS.
  sram_word_ctrl_row_decoder #(
    .ADDR_W (ADDR_W),
    .ROWS   (ROWS)
  ) u_row_decoder (
    .addr (addr_r),
    .en   (state_nxt == S_ACCESS),
    .sel  (dec_sel),
    .oob  (dec_oob)
  );

  // Next-state logic of the access sequencer.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      S_IDLE: begin
        if (req_valid) begin
          state_nxt = S_SETUP;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (last_access) begin
          state_nxt = S_HOLD;
        end else begin
          state_nxt = S_ACCESS;
        end
      end
      S_HOLD: begin
        if (we_r) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_RESP;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, request capture, registered array drive and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      we_r       <= 1'b0;
      addr_r     <= '0;
      cnt_r      <= '0;
      cell_sel_r <= '0;
      cell_r_w_r <= R_W_READ;
      cell_in_r  <= '0;
      rdata_r    <= '0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      cell_sel_r <= dec_sel;
      case (state_r)
        S_IDLE: begin
          // Strobe and write data go up with the SETUP entry, one edge
          // before any row is selected.
          if (req_valid) begin
            we_r       <= req_we;
            addr_r     <= req_addr;
            cell_r_w_r <= req_we ? R_W_WRITE : R_W_READ;
            cell_in_r  <= req_we ? req_wdata : '0;
          end
        end
        S_SETUP: begin
          cnt_r <= '0;
        end
        S_ACCESS: begin
          cnt_r <= cnt_r + 1'b1;
          if (last_access && !we_r) begin
            rdata_r <= dec_oob ? '1 : cell_out;
            err_r   <= dec_oob;
          end
        end
        S_HOLD: begin
          // Rows are already deselected here, so dropping the strobe
          // cannot disturb any cell.
          cell_r_w_r <= R_W_READ;
          cell_in_r  <= '0;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign req_ready = (state_r == S_IDLE);
  assign rsp_valid = (state_r == S_RESP);
  assign rsp_rdata = rdata_r;
  assign rsp_err   = err_r;
  assign cell_sel  = cell_sel_r;
  assign cell_r_w  = cell_r_w_r;
  assign cell_in   = cell_in_r;

endmodule
